jc_phase_decoder: RTL

Downstream consumer of the 4-bit Johnson counter with clock enable. It samples the counter's Q, CE, TC and CEO on every clock. It produces:
- a registered one-hot phase vector and a binary phase index;
- sticky error flags for illegal codes and illegal transitions;
- a wrap counter of completed Johnson cycles.

It sits between the counter and the phase-driven logic, so those consumers never decode raw Johnson codes.

---
 rtl/jc_phase_decoder.sv | 111 +++++++++++
 1 files changed

// File: rtl/jc_phase_decoder.sv
// Phase decoder for a 4-bit Johnson counter. Produces a registered one-hot and binary phase,
// sticky illegal-code / illegal-transition flags, and a count of completed Johnson cycles.
module jc_phase_decoder #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             ce,
  input  logic [3:0]       q,
  input  logic             tc,
  input  logic             ceo,
  input  logic             err_clr,
  output logic [7:0]       phase,
  output logic [2:0]       phase_idx,
  output logic             valid,
  output logic             code_err,
  output logic             seq_err,
  output logic [CNT_W-1:0] wraps,
  output logic             wrap_pulse
);

  typedef struct packed {
    logic       legal;
    logic [2:0] idx;
  } dec_t;

  function automatic dec_t decode(input logic [3:0] code);
    dec_t d;
    d.legal = 1'b1;
    d.idx   = 3'd0;
    case (code)
      4'b0000: d.idx = 3'd0;
      4'b0001: d.idx = 3'd1;
      4'b0011: d.idx = 3'd2;
      4'b0111: d.idx = 3'd3;
      4'b1111: d.idx = 3'd4;
      4'b1110: d.idx = 3'd5;
      4'b1100: d.idx = 3'd6;
      4'b1000: d.idx = 3'd7;
      default: d.legal = 1'b0;
    endcase
    return d;
  endfunction

  function automatic logic [3:0] next_code(input logic [3:0] code);
    return {code[2:0], ~code[3]};
  endfunction

  logic [3:0] q_d;
  logic       ce_d;
  logic       have_prev;
  dec_t       cur;
  dec_t       prv;
  logic       seq_bad;

  // tc carries no information beyond ceo (= ce & tc); only ceo is counted.
  logic unused_tc;
  assign unused_tc = tc;

  // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    cur     = decode(q);
    prv     = decode(q_d);
    seq_bad = 1'b0;
    // A jump to 0000 is the counter's own clear and is always accepted.
    if (have_prev && cur.legal && prv.legal && (q != 4'b0000)) begin
      if (ce_d) seq_bad = (q != next_code(q_d));
      else      seq_bad = (q != q_d);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      phase      <= '0;
      phase_idx  <= '0;
      valid      <= 1'b0;
      code_err   <= 1'b0;
      seq_err    <= 1'b0;
      wraps      <= '0;
      wrap_pulse <= 1'b0;
      q_d        <= 4'b0000;
      ce_d       <= 1'b0;
      have_prev  <= 1'b0;
    end else begin
      if (cur.legal) begin
        phase     <= 8'b1 << cur.idx;
        phase_idx <= cur.idx;
        valid     <= 1'b1;
      end else begin
        phase     <= '0;
        valid     <= 1'b0;
      end

      // A fresh error outranks a clear in the same cycle.
      if (!cur.legal)   code_err <= 1'b1;
      else if (err_clr) code_err <= 1'b0;

      if (seq_bad)      seq_err <= 1'b1;
      else if (err_clr) seq_err <= 1'b0;

      wrap_pulse <= ceo;
      if (ceo) wraps <= wraps + CNT_W'(1);

      q_d       <= q;
      ce_d      <= ce;
      have_prev <= 1'b1;
    end
  end

endmodule
